mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_sat_counter.sv | 14 +
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-master RAM arbiter.
package mem_bus_arbiter_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_XLEN    = 32;
  localparam int NUM_MST     = 2;
  localparam int MST_CPU     = 0;
  localparam int MST_DMA     = 1;
  localparam int RESP_STAGES = 1;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

  // Default-width request view; the arbiter builds a width-parameterised twin.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_XLEN-1:0]   wdata;
    logic [DEF_XLEN/8-1:0] wstrb;
  } bus_req_t;

  function automatic owner_t mst2own(input logic is_dma);
    return is_dma ? OWN_DMA : OWN_CPU;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter in front of the shared single-port RAM: one access per
// cycle, alternating on contention, read data routed back one cycle later.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_XLEN,
  parameter int CPU_FIRST = 1,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    cpu_stall_cnt,
  output logic [CNT_W-1:0]    dma_grant_cnt
);
  localparam int STRB_W = DATA_W/8;

  // Byte offset is dropped up front; the RAM is word-addressed.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-3:0] widx;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  req_t [NUM_MST-1:0]   bus;
  req_t                 sel;
  logic [NUM_MST-1:0]   req, gnt;
  owner_t               last_owner, last_nxt;
  logic [RESP_STAGES:0] vld_pipe, own_pipe;

  assign req           = {m1_req, m0_req};
  assign bus[MST_CPU]  = '{we: m0_we, widx: m0_addr[ADDR_W-1:2], wdata: m0_wdata, wstrb: m0_wstrb};
  assign bus[MST_DMA]  = '{we: m1_we, widx: m1_addr[ADDR_W-1:2], wdata: m1_wdata, wstrb: m1_wstrb};
  assign m0_gnt        = gnt[MST_CPU];
  assign m1_gnt        = gnt[MST_DMA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner <= OWN_NONE;
    else        last_owner <= last_nxt;
  end

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  always_comb begin
    gnt      = '0;
    last_nxt = last_owner;
    if (rst_n) begin
      if (req[MST_CPU] && req[MST_DMA]) begin
        unique case (last_owner)
          OWN_CPU: gnt[MST_DMA] = 1'b1;
          OWN_DMA: gnt[MST_CPU] = 1'b1;
          default: gnt[(CPU_FIRST != 0) ? MST_CPU : MST_DMA] = 1'b1;
        endcase
      end else begin
        gnt = req;
      end
      if (|gnt) last_nxt = mst2own(gnt[MST_DMA]);
    end
  end

  assign sel       = gnt[MST_DMA] ? bus[MST_DMA] : bus[MST_CPU];
  assign mem_en    = |gnt;
  assign mem_we    = mem_en & sel.we;
  assign mem_addr  = mem_en ? sel.widx  : '0;
  assign mem_wdata = mem_we ? sel.wdata : '0;
  assign mem_wstrb = mem_we ? sel.wstrb : '0;

  // Read response tracker: valid and owner travel alongside the RAM latency.
  assign vld_pipe[0] = mem_en & ~sel.we;
  assign own_pipe[0] = gnt[MST_DMA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[RESP_STAGES:1] <= '0;
      own_pipe[RESP_STAGES:1] <= '0;
    end else begin
      vld_pipe[RESP_STAGES:1] <= vld_pipe[RESP_STAGES-1:0];
      own_pipe[RESP_STAGES:1] <= own_pipe[RESP_STAGES-1:0];
    end
  end

  assign m0_rvalid = vld_pipe[RESP_STAGES] & ~own_pipe[RESP_STAGES];
  assign m1_rvalid = vld_pipe[RESP_STAGES] &  own_pipe[RESP_STAGES];
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  sat_counter #(.CNT_W(CNT_W)) u_cpu_stall (
    .clk(clk), .rst_n(rst_n), .inc(m0_req & ~m0_gnt), .cnt(cpu_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dma_grant (
    .clk(clk), .rst_n(rst_n), .inc(m1_gnt), .cnt(dma_grant_cnt)
  );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 1-cycle RAM.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] cpu_stall_cnt, dma_grant_cnt;

  // second instance: 4-bit counters, DMA wins the first tie
  logic        b_m0_req, b_m1_req;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_en, b_mem_we;
  logic [29:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h0;
  logic [3:0]  b_mem_wstrb;
  logic [3:0]  b_stall, b_dgnt;

  logic [31:0] ram [0:1023];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.CPU_FIRST(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .cpu_stall_cnt(cpu_stall_cnt), .dma_grant_cnt(dma_grant_cnt)
  );

  mem_bus_arbiter #(.CPU_FIRST(0), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_we(1'b1), .m0_addr(32'h0), .m0_wdata(32'h0), .m0_wstrb(4'hF),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(1'b1), .m1_addr(32'h4), .m1_wdata(32'h0), .m1_wstrb(4'hF),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata),
    .cpu_stall_cnt(b_stall), .dma_grant_cnt(b_dgnt)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:0]];
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; b_m0_req = 1'b1; b_m1_req = 1'b1;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b exp 00", {m0_gnt, m1_gnt}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin fails++; $display("FAIL rst_mem: got %b exp 00", {mem_en, mem_we}); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL rst_rvalid: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    checks++; if (cpu_stall_cnt !== 32'd0 || dma_grant_cnt !== 32'd0) begin fails++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", cpu_stall_cnt, dma_grant_cnt); end
    checks++; if ({b_m0_gnt, b_m1_gnt, b_mem_en} !== 3'b000) begin fails++; $display("FAIL rst_sat_gnt: got %b exp 000", {b_m0_gnt, b_m1_gnt, b_mem_en}); end
    do_reset();
  endtask

  task automatic test_cpu_reads();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL cr_gnt0: got %b exp 10", {m0_gnt, m1_gnt}); end
    checks++; if (mem_addr !== 30'h80 || mem_we !== 1'b0) begin fails++; $display("FAIL cr_addr0: got %h/%b exp 80/0", mem_addr, mem_we); end
    @(negedge clk); m0_addr = 32'h204;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_addr !== 30'h81) begin fails++; $display("FAIL cr_gnt1: got %b/%h exp 1/81", m0_gnt, mem_addr); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0000) begin fails++; $display("FAIL cr_rd0: got %b/%h exp 1/a0000000", m0_rvalid, m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin fails++; $display("FAIL cr_m1rv0: got %b exp 0", m1_rvalid); end
    @(negedge clk); m0_req = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin fails++; $display("FAIL cr_rd1: got %b/%h exp 1/12345678", m0_rvalid, m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0 || mem_en !== 1'b0) begin fails++; $display("FAIL cr_idle: got %b/%b exp 0/0", m1_rvalid, mem_en); end
    @(negedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0 || cpu_stall_cnt !== 32'd0) begin fails++; $display("FAIL cr_done: got %b/%0d exp 0/0", m0_rvalid, cpu_stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_alternation();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if ({m0_gnt, m1_gnt} !== exp_g) begin fails++; $display("FAIL alt_gnt[%0d]: got %b exp %b", i, {m0_gnt, m1_gnt}, exp_g); end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    checks++; if (dma_grant_cnt !== 32'd4) begin fails++; $display("FAIL alt_dma_cnt: got %0d exp 4", dma_grant_cnt); end
    checks++; if (cpu_stall_cnt !== 32'd4) begin fails++; $display("FAIL alt_stall_cnt: got %0d exp 4", cpu_stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_concurrent_writes();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h500; m0_wdata = 32'd5;          m0_wstrb = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30C; m1_wdata = 32'hA000_0003; m1_wstrb = 4'hF;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10 || mem_we !== 1'b1) begin fails++; $display("FAIL cw_gnt0: got %b/%b exp 10/1", {m0_gnt, m1_gnt}, mem_we); end
    checks++; if (mem_addr !== 30'h140 || mem_wdata !== 32'd5) begin fails++; $display("FAIL cw_bus0: got %h/%h exp 140/5", mem_addr, mem_wdata); end
    @(negedge clk); m0_req = 1'b0;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01 || mem_addr !== 30'hC3) begin fails++; $display("FAIL cw_gnt1: got %b/%h exp 01/c3", {m0_gnt, m1_gnt}, mem_addr); end
    checks++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL cw_norv0: got %b exp 0", m0_rvalid); end
    @(negedge clk); m1_req = 1'b0;
    #1;
    checks++; if (ram[10'hC3] !== 32'hA000_0003) begin fails++; $display("FAIL cw_mem_c3: got %h exp a0000003", ram[10'hC3]); end
    checks++; if (ram[10'h140] !== 32'd5) begin fails++; $display("FAIL cw_mem_140: got %h exp 5", ram[10'h140]); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL cw_norv1: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    @(negedge clk);
  endtask

  task automatic test_rearb();
    do_reset();
    m0_we = 1'b0; m1_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h200;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL ra_gnt0: got %b exp 01", {m0_gnt, m1_gnt}); end
    @(negedge clk); m0_req = 1'b1; m0_addr = 32'h204; m1_addr = 32'h204;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL ra_gnt1: got %b exp 10", {m0_gnt, m1_gnt}); end
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA000_0000) begin fails++; $display("FAIL ra_m1rd: got %b/%h exp 1/a0000000", m1_rvalid, m1_rdata); end
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin fails++; $display("FAIL ra_m0quiet: got %b/%h exp 0/0", m0_rvalid, m0_rdata); end
    @(negedge clk); m0_req = 1'b0;
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL ra_gnt2: got %b exp 01", {m0_gnt, m1_gnt}); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678 || m1_rdata !== 32'h0) begin fails++; $display("FAIL ra_m0rd: got %b/%h/%h exp 1/12345678/0", m0_rvalid, m0_rdata, m1_rdata); end
    @(negedge clk); m1_req = 1'b0;
    #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1234_5678) begin fails++; $display("FAIL ra_m1rd2: got %b/%h exp 1/12345678", m1_rvalid, m1_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    // read issued then reset one cycle later, while its data is due
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin fails++; $display("FAIL rm_gnt: got %b exp 1", m0_gnt); end
    @(negedge clk); m0_req = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b1) begin fails++; $display("FAIL rm_pre_rv: got %b exp 1", m0_rvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL rm_rv_async: got %b exp 0", m0_rvalid); end
    @(negedge clk); rst_n = 1'b1;
    // read granted in the very cycle reset asserts
    m0_req = 1'b1; m0_addr = 32'h204;
    #2; rst_n = 1'b0;
    #1;
    checks++; if ({m0_gnt, mem_en} !== 2'b00) begin fails++; $display("FAIL rm_gnt_rst: got %b exp 00", {m0_gnt, mem_en}); end
    m0_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL rm_rv_in_rst[%0d]: got %b exp 0", i, m0_rvalid); end
    end
    checks++; if (cpu_stall_cnt !== 32'd0 || dma_grant_cnt !== 32'd0) begin fails++; $display("FAIL rm_cnt: got %0d/%0d exp 0/0", cpu_stall_cnt, dma_grant_cnt); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL rm_rv_post[%0d]: got %b exp 0", i, m0_rvalid); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i == 0) begin
        checks++; if ({b_m0_gnt, b_m1_gnt} !== 2'b01) begin fails++; $display("FAIL sat_first: got %b exp 01", {b_m0_gnt, b_m1_gnt}); end
      end
      if (i == 10) begin
        checks++; if (b_stall !== 4'd5) begin fails++; $display("FAIL sat_mid: got %0d exp 5", b_stall); end
      end
      if (i == 30) begin
        checks++; if (b_stall !== 4'd15) begin fails++; $display("FAIL sat_at_max: got %0d exp 15", b_stall); end
      end
      @(negedge clk);
    end
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    #1;
    checks++; if (b_stall !== 4'hF) begin fails++; $display("FAIL sat_stall: got %0d exp 15", b_stall); end
    checks++; if (b_dgnt !== 4'hF) begin fails++; $display("FAIL sat_dma: got %0d exp 15", b_dgnt); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h80] = 32'hA000_0000;
    ram[10'h81] = 32'h1234_5678;
    m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = 4'hF;
    m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = 4'hF;
    @(negedge clk);
    test_reset();
    test_cpu_reads();
    test_alternation();
    test_concurrent_writes();
    test_rearb();
    test_reset_mid_read();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
